// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler: state encoding,
// datapath width, default requester count and the divide-by-zero quotient.
package div_sched_pkg;

    localparam int DIV_W    = 16;
    localparam int NREQ_DEF = 4;

    localparam logic [DIV_W-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

endpackage

// File: rtl/div_sched_if.sv
// Requester and divider-core signals of div_sched. The slave modport is the
// scheduler's view; the master modport is the surrounding issue logic/divider.
interface div_sched_if import div_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = DIV_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] opa;
    logic [NREQ*W-1:0] opb;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              ds;
    logic [W-1:0]      da;
    logic [W-1:0]      db;
    logic [W-1:0]      dq;
    logic [W-1:0]      dr;
    logic              df;
    logic              vld;
    logic [IDW-1:0]    vid;
    logic [W-1:0]      qo;
    logic [W-1:0]      ro;
    logic              dz;

    modport slave (
        input  req, opa, opb, dq, dr, df,
        output gnt, busy, ds, da, db, vld, vid, qo, ro, dz
    );

    modport master (
        output req, opa, opb, dq, dr, df,
        input  gnt, busy, ds, da, db, vld, vid, qo, ro, dz
    );

endinterface

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping past NREQ-1 back to 0. Returns one-hot grant and its index.
module rr_arbiter import div_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW:0] k;

    always_comb begin
        k   = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = {1'b0, ptr} + (IDW+1)'(i);
            if (k >= (IDW+1)'(NREQ)) begin
                k = k - (IDW+1)'(NREQ);
            end
            if (!any && req[k[IDW-1:0]]) begin
                any = 1'b1;
                idx = k[IDW-1:0];
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one sequential divider among NREQ requesters.
// Optional DIV_SCHED_DZ_EN: zero divisors are answered locally, never issued.
module div_sched import div_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = DIV_W
) (
    input  logic       c,
    input  logic       rst,
    div_sched_if.slave bus
);
    // state    | meaning
    // S_IDLE   | arbitrate when DF low; also answers a pending zero-divisor op
    // S_ISSUE  | DS held high, operands stable, waiting for DF
    // S_DRAIN  | result delivered, waiting for DF to fall before next grant

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [IDW-1:0]  nxt_id;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_gnt;
    logic            win_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            zero_div;
    logic            dz_pend;
    logic [W-1:0]    dz_a;

    logic [NREQ-1:0] gnt_q;
    logic            ds_q;
    logic [W-1:0]    da_q;
    logic [W-1:0]    db_q;
    logic            vld_q;
    logic [IDW-1:0]  vid_q;
    logic [W-1:0]    qo_q;
    logic [W-1:0]    ro_q;
    logic            dz_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_a = bus.opa[i*W +: W];
                sel_b = bus.opb[i*W +: W];
            end
        end
    end

`ifdef DIV_SCHED_DZ_EN
    assign zero_div = (sel_b == '0);
`else
    assign zero_div = 1'b0;
`endif

    assign nxt_id = (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            cur_id  <= '0;
            gnt_q   <= '0;
            ds_q    <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
            vld_q   <= 1'b0;
            vid_q   <= '0;
            qo_q    <= '0;
            ro_q    <= '0;
            dz_q    <= 1'b0;
            dz_pend <= 1'b0;
            dz_a    <= '0;
        end else begin
            gnt_q <= '0;
            vld_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dz_pend) begin
                        dz_pend <= 1'b0;
                        vld_q   <= 1'b1;
                        vid_q   <= cur_id;
                        qo_q    <= '1;
                        ro_q    <= dz_a;
                        dz_q    <= 1'b1;
                        ptr     <= nxt_id;
                    end else if (win_any && !bus.df) begin
                        gnt_q  <= win_gnt;
                        cur_id <= win_idx;
                        // Zero divisor is answered next cycle without touching the divider
                        if (zero_div) begin
                            dz_pend <= 1'b1;
                            dz_a    <= sel_a;
                        end else begin
                            da_q  <= sel_a;
                            db_q  <= sel_b;
                            ds_q  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.df) begin
                        qo_q  <= bus.dq;
                        ro_q  <= bus.dr;
                        vid_q <= cur_id;
                        vld_q <= 1'b1;
                        dz_q  <= 1'b0;
                        ds_q  <= 1'b0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.df) begin
                        ptr   <= nxt_id;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    ds_q  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = (state != S_IDLE);
    assign bus.ds   = ds_q;
    assign bus.da   = da_q;
    assign bus.db   = db_q;
    assign bus.vld  = vld_q;
    assign bus.vid  = vid_q;
    assign bus.qo   = qo_q;
    assign bus.ro   = ro_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a small signed-divider model on DS/DF.
// Build with +define+DIV_SCHED_DZ_EN to exercise the zero-divisor shortcut.
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int LAT  = 2;

    logic c   = 1'b0;
    logic rst = 1'b0;
    logic df_force_en  = 1'b0;
    logic df_force_val = 1'b0;
    int   mdl_cnt;
    int   checks = 0;
    int   errors = 0;

    always #5 c = ~c;

    div_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    div_sched #(.NREQ(NREQ), .W(W)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    // Divider model: DF rises LAT+1 edges after DS is seen, holds while DS high
    always @(posedge c or posedge rst) begin
        if (df_force_en) begin
            bus.df  <= df_force_val;
            mdl_cnt <= LAT;
        end else if (rst) begin
            bus.df  <= 1'b0;
            bus.dq  <= '0;
            bus.dr  <= '0;
            mdl_cnt <= LAT;
        end else if (bus.ds !== 1'b1) begin
            bus.df  <= 1'b0;
            mdl_cnt <= LAT;
        end else if (!bus.df) begin
            if (mdl_cnt == 0) begin
                bus.df <= 1'b1;
                if (bus.db == '0) begin
                    bus.dq <= '1;
                    bus.dr <= bus.da;
                end else begin
                    bus.dq <= $signed(bus.da) / $signed(bus.db);
                    bus.dr <= $signed(bus.da) % $signed(bus.db);
                end
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(negedge c);
        bus.req = '0;
        rst = 1'b1;
        @(negedge c);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output bit to);
        to = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge c);
            if (bus.gnt != '0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_vld(output bit to);
        to = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge c);
            if (bus.vld === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge c);
            if (bus.busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge c);
        rst = 1'b1;
        bus.req = '0;
        #1;
        checks++;
        if ({bus.busy, bus.ds, bus.vld, bus.dz} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/ds/vld/dz=%b required 0000",
                     {bus.busy, bus.ds, bus.vld, bus.dz});
        end
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: got %b required 0000", bus.gnt);
        end
        checks++;
        if ({bus.da, bus.db} !== 32'h0) begin
            errors++;
            $display("FAIL reset_da_db: got %h required 0", {bus.da, bus.db});
        end
        checks++;
        if ({bus.qo, bus.ro, bus.vid} !== 34'h0) begin
            errors++;
            $display("FAIL reset_results: got %h required 0", {bus.qo, bus.ro, bus.vid});
        end
        @(negedge c);
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit to, ds_ok, vld_late, df_prev;
        pulse_reset();
        @(negedge c);
        bus.opa[15:0] = 16'd2000;
        bus.opb[15:0] = 16'd45;
        bus.req = 4'b0001;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: got %b timeout=%0d required 0001", bus.gnt, to);
        end
        checks++;
        if (bus.ds !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ds_rise: got ds=%b busy=%b required 1 1", bus.ds, bus.busy);
        end
        checks++;
        if (bus.da !== 16'd2000 || bus.db !== 16'd45) begin
            errors++;
            $display("FAIL single_operands: got da=%0d db=%0d required 2000 45", bus.da, bus.db);
        end
        bus.req = '0;
        @(negedge c);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_gnt_pulse: got %b required 0000", bus.gnt);
        end
        to = 1'b1;
        ds_ok = 1'b1;
        vld_late = 1'b0;
        df_prev = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.vld === 1'b1) begin
                to = 1'b0;
                break;
            end
            if (df_prev) vld_late = 1'b1;
            if (bus.ds !== 1'b1) ds_ok = 1'b0;
            df_prev = bus.df;
            @(negedge c);
        end
        checks++;
        if (to || !ds_ok || vld_late) begin
            errors++;
            $display("FAIL single_ds_hold: got timeout=%0d ds_held=%0d vld_late=%0d required 0 1 0",
                     to, ds_ok, vld_late);
        end
        checks++;
        if (bus.vid !== 2'd0 || bus.qo !== 16'd44 || bus.ro !== 16'd20 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got vid=%0d qo=%0d ro=%0d dz=%b required 0 44 20 0",
                     bus.vid, bus.qo, bus.ro, bus.dz);
        end
        checks++;
        if (bus.ds !== 1'b0) begin
            errors++;
            $display("FAIL single_ds_fall: got %b required 0", bus.ds);
        end
        @(negedge c);
        checks++;
        if (bus.vld !== 1'b0 || bus.qo !== 16'd44) begin
            errors++;
            $display("FAIL single_vld_pulse: got vld=%b qo=%0d required 0 44", bus.vld, bus.qo);
        end
        wait_idle(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL single_idle: got busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_all_four();
        logic [15:0] exp_q [4];
        logic [15:0] exp_r [4];
        logic [3:0]  exp_g;
        bit to;
        exp_q = '{16'd44, 16'hFFD4, 16'hFFD4, 16'd44};
        exp_r = '{16'd20, 16'd20, 16'hFFEC, 16'hFFEC};
        pulse_reset();
        @(negedge c);
        bus.opa = {16'hF830, 16'hF830, 16'd2000, 16'd2000};
        bus.opb = {16'hFFD3, 16'd45, 16'hFFD3, 16'd45};
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'(1 << k);
            wait_gnt(to);
            checks++;
            if (to || bus.gnt !== exp_g) begin
                errors++;
                $display("FAIL all4_gnt[%0d]: got %b timeout=%0d required %b", k, bus.gnt, to, exp_g);
            end
            bus.req[k] = 1'b0;
            wait_vld(to);
            checks++;
            if (to || bus.vid !== 2'(k) || bus.qo !== exp_q[k] || bus.ro !== exp_r[k]) begin
                errors++;
                $display("FAIL all4_result[%0d]: got vid=%0d qo=%h ro=%h timeout=%0d required %0d %h %h",
                         k, bus.vid, bus.qo, bus.ro, to, k, exp_q[k], exp_r[k]);
            end
            wait_idle(to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL all4_idle[%0d]: got busy=%b required 0", k, bus.busy);
            end
        end
    endtask

    task automatic test_round_robin();
        bit to;
        pulse_reset();
        @(negedge c);
        bus.opa = {16'd0, 16'd9, 16'd100, 16'd50};
        bus.opb = {16'd1, 16'd4, 16'd7, 16'd5};
        bus.req = 4'b0010;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rr_first: got %b timeout=%0d required 0010", bus.gnt, to);
        end
        bus.req = '0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd1 || bus.qo !== 16'd14 || bus.ro !== 16'd2) begin
            errors++;
            $display("FAIL rr_first_result: got vid=%0d qo=%0d ro=%0d required 1 14 2",
                     bus.vid, bus.qo, bus.ro);
        end
        wait_idle(to);
        bus.req = 4'b0101;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL rr_after1: got %b timeout=%0d required 0100", bus.gnt, to);
        end
        bus.req[2] = 1'b0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd2 || bus.qo !== 16'd2 || bus.ro !== 16'd1) begin
            errors++;
            $display("FAIL rr_req2_result: got vid=%0d qo=%0d ro=%0d required 2 2 1",
                     bus.vid, bus.qo, bus.ro);
        end
        wait_idle(to);
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap: got %b timeout=%0d required 0001", bus.gnt, to);
        end
        bus.req = '0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd0 || bus.qo !== 16'd10 || bus.ro !== 16'd0) begin
            errors++;
            $display("FAIL rr_req0_result: got vid=%0d qo=%0d ro=%0d required 0 10 0",
                     bus.vid, bus.qo, bus.ro);
        end
        wait_idle(to);
    endtask

    task automatic test_reset_mid_issue();
        bit to, quiet;
        pulse_reset();
        @(negedge c);
        bus.opa[15:0] = 16'd2000;
        bus.opb[15:0] = 16'd45;
        bus.req = 4'b0001;
        wait_gnt(to);
        @(negedge c);
        df_force_val = 1'b1;
        df_force_en  = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ds !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got ds=%b busy=%b required 0 0", bus.ds, bus.busy);
        end
        @(negedge c);
        rst = 1'b0;
        quiet = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge c);
            if (bus.gnt !== 4'b0000 || bus.vld !== 1'b0 || bus.ds !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midrst_df_guard: got a grant/vld/ds while DF high, required none");
        end
        df_force_val = 1'b0;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0001 || bus.qo !== 16'd0) begin
            errors++;
            $display("FAIL midrst_regrant: got gnt=%b qo=%0d timeout=%0d required 0001 0",
                     bus.gnt, bus.qo, to);
        end
        df_force_en = 1'b0;
        bus.req = '0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd0 || bus.qo !== 16'd44 || bus.ro !== 16'd20) begin
            errors++;
            $display("FAIL midrst_result: got vid=%0d qo=%0d ro=%0d required 0 44 20",
                     bus.vid, bus.qo, bus.ro);
        end
        wait_idle(to);
    endtask

    task automatic test_dz();
        bit to;
        pulse_reset();
        @(negedge c);
        bus.opa = {16'd100, 16'd1234, 16'd30, 16'd0};
        bus.opb = {16'd7, 16'd0, 16'd3, 16'd0};
        bus.req = 4'b0100;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL dz_gnt: got %b timeout=%0d required 0100", bus.gnt, to);
        end
        bus.req = '0;
`ifdef DIV_SCHED_DZ_EN
        checks++;
        if (bus.ds !== 1'b0) begin
            errors++;
            $display("FAIL dz_no_issue: got ds=%b required 0", bus.ds);
        end
        @(negedge c);
        checks++;
        if (bus.vld !== 1'b1 || bus.vid !== 2'd2 || bus.qo !== 16'hFFFF ||
            bus.ro !== 16'd1234 || bus.dz !== 1'b1 || bus.ds !== 1'b0) begin
            errors++;
            $display("FAIL dz_result: got vld=%b vid=%0d qo=%h ro=%0d dz=%b ds=%b required 1 2 ffff 1234 1 0",
                     bus.vld, bus.vid, bus.qo, bus.ro, bus.dz, bus.ds);
        end
        @(negedge c);
        bus.req = 4'b1010;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL dz_ptr_advance: got %b timeout=%0d required 1000", bus.gnt, to);
        end
        bus.req = '0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd3 || bus.qo !== 16'd14 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL dz_followup: got vid=%0d qo=%0d dz=%b required 3 14 0",
                     bus.vid, bus.qo, bus.dz);
        end
`else
        checks++;
        if (bus.ds !== 1'b1 || bus.db !== 16'd0 || bus.da !== 16'd1234) begin
            errors++;
            $display("FAIL dz_forward: got ds=%b da=%0d db=%0d required 1 1234 0",
                     bus.ds, bus.da, bus.db);
        end
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd2 || bus.dz !== 1'b0 || bus.qo !== 16'hFFFF || bus.ro !== 16'd1234) begin
            errors++;
            $display("FAIL dz_disabled_result: got vid=%0d dz=%b qo=%h ro=%0d required 2 0 ffff 1234",
                     bus.vid, bus.dz, bus.qo, bus.ro);
        end
`endif
        wait_idle(to);
    endtask

    task automatic test_req_drop();
        bit to, quiet;
        pulse_reset();
        @(negedge c);
        bus.opa[63:48] = 16'd100;
        bus.opb[63:48] = 16'd7;
        bus.req = 4'b1000;
        wait_gnt(to);
        checks++;
        if (to || bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_gnt: got %b timeout=%0d required 1000", bus.gnt, to);
        end
        @(negedge c);
        bus.req = '0;
        wait_vld(to);
        checks++;
        if (to || bus.vid !== 2'd3 || bus.qo !== 16'd14 || bus.ro !== 16'd2) begin
            errors++;
            $display("FAIL drop_result: got vid=%0d qo=%0d ro=%0d timeout=%0d required 3 14 2",
                     bus.vid, bus.qo, bus.ro, to);
        end
        wait_idle(to);
        quiet = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge c);
            if (bus.gnt !== 4'b0000 || bus.ds !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL drop_no_regrant: got a grant with no request, required none");
        end
    endtask

    initial begin
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        test_reset();
        test_single();
        test_all_four();
        test_round_robin();
        test_reset_mid_issue();
        test_dz();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler sharing the single 16-bit sequential divider among up to NREQ requesters. Each requester presents a dividend/divisor pair with a request. The block grants one requester at a time, drives the divider's start/operand inputs, holds start until finish, then returns quotient and remainder tagged with the requester ID. It sits between the ALU issue logic and the divider core and is the only master of the divider's start input.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width; matches the divider datapath
- C  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  NREQ  per-requester request level
- OPA  in  NREQ*W  packed dividends; requester i at [i*W +: W]
- OPB  in  NREQ*W  packed divisors; same packing
- GNT  out  NREQ  one-hot, one-cycle pulse when requester's operands are latched
- BUSY  out  1  high whenever state is not IDLE
- DS  out  1  divider start; held high until DF seen
- DA, DB  out  W each  divider dividend/divisor, registered
- DQ, DR  in  W each  divider quotient/remainder
- DF  in  1  divider finish
- VLD  out  1  one-cycle result-valid pulse
- VID  out  $clog2(NREQ)  requester ID of the result
- QO, RO  out  W each  latched quotient/remainder
- DZ  out  1  divide-by-zero flag, qualified by VLD

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: if REQ nonzero and DF==0, the arbiter picks winner w (first set bit searching upward from pointer, wrapping). On that edge: DA<=OPA[w], DB<=OPB[w], GNT[w]=1 for one cycle, DS<=1, state->ISSUE. If DF==1, no grant (divider still finishing).
- ISSUE: DS held at 1, DA/DB stable. On edge with DF==1: QO<=DQ, RO<=DR, VID<=w, VLD=1 for one cycle, DZ=0, DS<=0, state->DRAIN.
- DRAIN: DS=0. On edge with DF==0: pointer<=w+1 (mod NREQ), state->IDLE.
- Requesters hold REQ and operands until their GNT. REQ still high after GNT is a new request. REQ dropped after grant does not abort the operation.
- Operands pass through unmodified. Signedness is the divider's concern.
- Reset: state IDLE, pointer 0; DS, GNT, VLD, DZ, BUSY = 0; DA, DB, QO, RO, VID = 0.
- Reset mid-ISSUE: DS drops immediately (async), and the result is discarded. The first post-reset grant waits for DF==0 via the IDLE guard.

## Timing
- Grant edge G: GNT pulse and DS rise in cycle after G; DS remains high until the edge where DF is sampled 1.
- VLD asserted in the cycle after that edge. QO/RO/VID are valid with VLD and hold until the next VLD.
- Minimum grant-to-grant spacing: divider latency + 2 cycles (DRAIN plus IDLE arbitration).
- Only one operation outstanding. No requester is starved: it waits at most NREQ-1 operations.

## Configuration
- DIV_SCHED_DZ_EN defined: in IDLE, a winner with OPB[w]==0 is not issued. GNT pulses, DS stays 0, and the next cycle has VLD=1, VID=w, QO=all ones, RO=OPA[w], DZ=1. State returns to IDLE and the pointer advances.
- Undefined: zero divisors are forwarded to the divider like any other operand. DZ is tied 0.

## Structure
- Package div_sched_pkg: state enum (IDLE, ISSUE, DRAIN), DIV_W=16, NREQ default, DZ_QUOT constant (all ones).
- Sub-module rr_arbiter: combinational round-robin pick from REQ and pointer. Outputs one-hot grant and index. The pointer register stays in div_sched.

## Test plan
- Single request: REQ[0], A=2000, B=45 -> GNT[0] one cycle, DS high until DF, VLD with VID=0, QO=44, RO=20.
- All four REQ high from reset, operands 2000/45, 2000/-45, -2000/45, -2000/-45 -> grants 0,1,2,3 in order. Results are 44/20, -44/20, -44/-20, 44/-20.
- Round-robin: serve 1, then REQ[0] and REQ[2] together -> 2 granted before 0.
- RST asserted mid-ISSUE -> DS and BUSY 0 immediately, no VLD. After release with DF held 1, no grant until DF falls.
- DIV_SCHED_DZ_EN, A=1234, B=0 -> DS never rises, VLD one cycle after GNT, QO=16'hFFFF, RO=1234, DZ=1. Without the macro -> DS issued, DZ=0.
- REQ dropped one cycle after GNT -> operation completes, VLD delivered with correct VID.
